// File: rtl/mul_div_controller.sv
// mul_div_controller: sequences one RV32 M-extension request at a time.
// Divide special cases and repeats of the previous request are answered
// directly. All other requests go to the external multiplier or divider.
//
// Core handshake: mul_ext_valid is held high with stable funct3/rs1/rs2
// until mul_ext_ready pulses for one cycle. result is meaningful only in
// that cycle. The core drops mul_ext_valid at the edge that ends the pulse.
// A flush during the response cycle suppresses the pulse.
// Unit handshake: *_start pulses once. The unit answers with a one-cycle
// *_ready pulse, and *_rd is valid during that pulse.
module mul_div_controller #(
    parameter int XLEN     = 32,
    parameter int REUSE_EN = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            mul_ext_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            mul_ext_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [2:0]      unit_funct3,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic            mul_start,
    input  logic            mul_ready,
    input  logic [XLEN-1:0] mul_rd,
    output logic            div_start,
    input  logic            div_ready,
    input  logic [XLEN-1:0] div_rd,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_WAIT = 3'd2,
        S_RESP     = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};

    state_t            state;
    logic              resp_q;
    logic              cache_valid;
    logic [2:0]        cache_funct3;
    logic [XLEN-1:0]   cache_a;
    logic [XLEN-1:0]   cache_b;
    logic [XLEN-1:0]   cache_result;

    logic              req_is_div;
    logic              req_div_zero;
    logic              req_overflow;
    logic              req_hit;
    logic              wait_ready;
    logic [XLEN-1:0]   wait_rd;

    // Classify the incoming request and select the outstanding unit's reply
    always_comb begin
        req_is_div   = funct3[2];
        req_div_zero = req_is_div && (rs2 == '0);
        req_overflow = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (rs1 == SIGNED_MIN) && (rs2 == ALL_ONES);
        req_hit      = (REUSE_EN != 0) && cache_valid &&
                       (funct3 == cache_funct3) && (rs1 == cache_a) && (rs2 == cache_b);
        // The latched class tells which unit is outstanding in WAIT and DRAIN.
        wait_ready   = unit_funct3[2] ? div_ready : mul_ready;
        wait_rd      = unit_funct3[2] ? div_rd : mul_rd;
    end

    // Control FSM with registered outputs, operand latches and result cache
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            resp_q       <= 1'b0;
            busy         <= 1'b0;
            mul_start    <= 1'b0;
            div_start    <= 1'b0;
            result       <= '0;
            unit_funct3  <= '0;
            unit_a       <= '0;
            unit_b       <= '0;
            cache_valid  <= 1'b0;
            cache_funct3 <= '0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_result <= '0;
        end else begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            resp_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mul_ext_valid && !flush) begin
                        unit_funct3 <= funct3;
                        unit_a      <= rs1;
                        unit_b      <= rs2;
                        busy        <= 1'b1;
                        if (req_div_zero) begin
                            // DIV/DIVU give all ones, REM/REMU give the dividend.
                            result <= funct3[1] ? rs1 : ALL_ONES;
                            state  <= S_RESP;
                            resp_q <= 1'b1;
                        end else if (req_overflow) begin
                            result <= funct3[1] ? '0 : SIGNED_MIN;
                            state  <= S_RESP;
                            resp_q <= 1'b1;
                        end else if (req_hit) begin
                            result <= cache_result;
                            state  <= S_RESP;
                            resp_q <= 1'b1;
                        end else if (req_is_div) begin
                            state     <= S_DIV_WAIT;
                            div_start <= 1'b1;
                        end else begin
                            state     <= S_MUL_WAIT;
                            mul_start <= 1'b1;
                        end
                    end
                end
                S_MUL_WAIT, S_DIV_WAIT: begin
                    if (flush) begin
                        // A reply arriving with the flush already settles the unit.
                        if (wait_ready) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (wait_ready) begin
                        result       <= wait_rd;
                        cache_valid  <= 1'b1;
                        cache_funct3 <= unit_funct3;
                        cache_a      <= unit_a;
                        cache_b      <= unit_b;
                        cache_result <= wait_rd;
                        state        <= S_RESP;
                        resp_q       <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_DRAIN: begin
                    if (wait_ready) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mul_ext_ready = resp_q && !flush;
    assign state_dbg     = state;

endmodule

// File: doc/mul_div_controller.md
# mul_div_controller

Sequencing controller for the RV32 M-extension in the multicycle core.
- Accepts one M-class request at a time from the core's execute stage and dispatches it to the external multiplier or divider unit.
- Resolves the RISC-V divide special cases (divide by zero, signed overflow) without invoking the divider.
- Keeps a one-entry last-result cache and returns a single result to the core over a valid/ready handshake.
- Sits between the core control FSM and the mul/div datapath units, and owns their start/ready handshakes.

## Interface
Parameters:
- XLEN, 32, operand/result width.
- REUSE_EN, 1, enables the last-result cache (0: every non-special request goes to a unit).

Ports (one clock; asynchronous active-low reset):
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- mul_ext_valid  in  1  request from core; held high until mul_ext_ready.
- funct3  in  3  M-op select, valid with mul_ext_valid.
- rs1, rs2  in  XLEN  operands, valid with mul_ext_valid.
- flush  in  1  abort current request (trap/interrupt).
- mul_ext_ready  out  1  one-cycle pulse, result valid.
- result  out  XLEN  result, valid only while mul_ext_ready=1.
- busy  out  1  high in any state except IDLE.
- unit_funct3  out  3  registered funct3 to the unit decoders.
- unit_a, unit_b  out  XLEN  registered operands to the units.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_ready  in  1  multiplier done pulse.
- mul_rd  in  XLEN  multiplier result, valid with mul_ready.
- div_start  out  1  one-cycle start pulse to the divider.
- div_ready  in  1  divider done pulse.
- div_rd  in  XLEN  divider result, valid with div_ready.

## Operation
- Class: funct3[2]=0 → multiply (MUL/MULH/MULHSU/MULHU); funct3[2]=1 → divide (DIV/DIVU/REM/REMU).
- States: IDLE, MUL_WAIT, DIV_WAIT, RESP, DRAIN.
- IDLE + mul_ext_valid:
  - Latch funct3/rs1/rs2 into unit_funct3/unit_a/unit_b.
  - Select the next state by priority:
    1. Divide class with rs2=0 → RESP. DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
    2. funct3=DIV or REM with rs1=0x80000000 and rs2=0xFFFFFFFF → RESP. DIV result 0x80000000; REM result 0.
    3. Cache hit (REUSE_EN, cache valid, funct3 and rs1 and rs2 equal to the cached entry) → RESP with the cached result.
    4. Otherwise → MUL_WAIT or DIV_WAIT.
- MUL_WAIT/DIV_WAIT:
  - The matching *_start is high only in the first cycle of the state.
  - The unit's ready is sampled every cycle of the state, including the start cycle.
  - On ready: latch *_rd into the result register, update the cache (funct3, operands, result, valid=1), go to RESP.
- RESP: mul_ext_ready=1 for exactly one cycle, then IDLE. The core drops mul_ext_valid at the same edge, so IDLE never re-accepts the same request.
- Special-case results do not update the cache.
- flush:
  - In IDLE or RESP: next state IDLE, no ready pulse.
  - In MUL_WAIT or DIV_WAIT: next state DRAIN; the cache is not updated.
  - DRAIN waits for the outstanding unit's ready, discards the result, then goes to IDLE.
  - mul_ext_valid is ignored during DRAIN.
- flush has priority over ready in the same cycle. Ready arriving together with flush completes the drain immediately: go to IDLE.
- Only one unit is ever started at a time; no *_start is issued while a unit is outstanding.
- Cache is invalidated by reset only.

## Timing
- Reset values:
  - State IDLE; busy, mul_ext_ready, mul_start, div_start = 0.
  - result, unit_a, unit_b, unit_funct3 = 0.
  - Cache valid = 0.
- Request accepted at edge E0.
- Fast path (special case or cache hit): mul_ext_ready in the cycle after E0, i.e. latency 1.
- Unit path:
  - *_start in cycle 1.
  - Unit ready in cycle 1+N (N≥0).
  - mul_ext_ready in cycle 2+N.
- Back-to-back: the earliest next acceptance is the cycle after the RESP cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The units are reset by the same resetn, so no drain is needed.

## Test plan
- MUL, rs1=7, rs2=6, multiplier ready 3 cycles after start → one mul_start pulse, mul_ext_ready with result 42 in cycle 5, busy low afterwards.
- DIVU, rs1=100, rs2=0 → no div_start, mul_ext_ready next cycle with result 0xFFFFFFFF. Repeat with REMU → result 100.
- DIV, rs1=0x80000000, rs2=0xFFFFFFFF → result 0x80000000 at latency 1. Repeat with REM → result 0. No div_start in either case.
- DIV 20/3 via the divider (result 6), then an identical DIV request → second request hits the cache: latency 1, result 6, no div_start.
- DIVU issued, flush in the second DIV_WAIT cycle → DRAIN. Request held during DRAIN is not accepted. div_ready returns to IDLE with no mul_ext_ready and no cache update. A following MULHU 0xFFFFFFFF×2 → result 1.
- resetn asserted low during MUL_WAIT → all outputs 0 immediately. After release, an identical request misses the cache and issues mul_start.
